// File: rtl/mem_pkg.sv
// Shared encodings and request-entry layout for the core memory request port.
package mem_pkg;

  localparam logic W_BYTE = 1'b0;
  localparam logic W_WORD = 1'b1;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_RESP
  } mem_state_e;

  // 35-bit queue entry: addr16, data16, width, cmd, tag (MSB to LSB)
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              width;
    logic              cmd;
    logic              tag;
  } mem_req_t;

  localparam int unsigned REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; a pop on the same edge frees a slot for a push when full.
module mem_req_fifo #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned W      = 35
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [W-1:0]                din_i,
  output logic [W-1:0]                dout_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(QDEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(QDEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_port_unit.sv
// Core memory request responder: queues tagged requests, runs them as 1-2 byte
// cycles on the 8-bit external bus and returns read data as a tagged pulse.
module mem_port_unit
  import mem_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned AW     = 16
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic [AW-1:0] mem_rq_addr,
  input  logic          mem_rq_prepare_addr,
  input  logic [15:0]   mem_rq_data,
  input  logic          mem_rq_start,
  input  logic          mem_rq_width,
  input  logic          mem_rq_cmd,
  input  logic          mem_t_id,
  output logic [15:0]   mem_data_in,
  output logic          mem_data_t_wr,
  output logic          mem_data_wr,
  output logic          core_hold,
  output logic          ovf_err,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_dout,
  input  logic [7:0]    bus_din,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic          bus_ready
);

  mem_state_e         state_q, state_d;
  logic [AW-1:0]      mar_q;
  mem_req_t           act_q;
  mem_req_t           req_in;
  logic [7:0]         lo_q;
  logic [15:0]        res_q;
  logic               res_tag_q;
  logic               ovf_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [REQ_W-1:0]   fifo_dout;
  logic [REQ_W-1:0]   fifo_din;
  logic [$clog2(QDEPTH):0] fifo_count;
  logic               pop;

  always_comb begin
    req_in       = '0;
    req_in.addr  = mem_rq_prepare_addr ? mem_rq_addr : mar_q;
    req_in.data  = mem_rq_data;
    req_in.width = mem_rq_width;
    req_in.cmd   = mem_rq_cmd;
    req_in.tag   = mem_t_id;
  end

  assign fifo_din = req_in;
  assign pop      = (state_q == ST_IDLE) && !fifo_empty;

  mem_req_fifo #(
    .QDEPTH (QDEPTH),
    .W      (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (a_rst),
    .push_i  (mem_rq_start),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign core_hold     = (fifo_count == ($clog2(QDEPTH)+1)'(QDEPTH));
  assign ovf_err       = ovf_q;
  assign mem_data_in   = res_q;
  assign mem_data_t_wr = res_tag_q;

  always_comb begin
    state_d     = state_q;
    bus_addr    = '0;
    bus_dout    = '0;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    mem_data_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LO;
      end
      ST_LO: begin
        bus_addr = act_q.addr;
        bus_dout = act_q.data[7:0];
        bus_rd   = (act_q.cmd == CMD_RD);
        bus_wr   = (act_q.cmd == CMD_WR);
        if (bus_ready) begin
          if (act_q.width == W_WORD)   state_d = ST_HI;
          else if (act_q.cmd == CMD_RD) state_d = ST_RESP;
          else                          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        bus_addr = act_q.addr + AW'(1);
        bus_dout = act_q.data[15:8];
        bus_rd   = (act_q.cmd == CMD_RD);
        bus_wr   = (act_q.cmd == CMD_WR);
        if (bus_ready) state_d = (act_q.cmd == CMD_RD) ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        mem_data_wr = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      act_q     <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      res_tag_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_rq_prepare_addr) mar_q <= mem_rq_addr;
      if (pop) act_q <= mem_req_t'(fifo_dout);
      if (mem_rq_start && fifo_full && !pop) ovf_q <= 1'b1;
      if (state_q == ST_LO && bus_ready) lo_q <= bus_din;
      // Result register is loaded on the edge into RESP and then holds.
      if (state_q != ST_RESP && state_d == ST_RESP) begin
        res_q     <= (state_q == ST_HI) ? {bus_din, lo_q} : {8'h00, bus_din};
        res_tag_q <= act_q.tag;
      end
    end
  end

endmodule
